// File: rtl/mem_req_scheduler.sv
// mem_req_scheduler: shares one memory port between icache and dcache, routes tagged responses to their owner
module mem_req_scheduler #(
    parameter int ADDR_W          = 32,
    parameter int BLOCK_W         = 64,
    parameter int TAG_W           = 4,
    parameter int MAX_OUTSTANDING = 15,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               dc_req_valid,
    input  logic [1:0]         dc_req_cmd,
    input  logic               dc_req_prior,
    input  logic [ADDR_W-1:0]  dc_req_addr,
    input  logic [BLOCK_W-1:0] dc_req_data,
    output logic               dc_req_accepted,
    input  logic               ic_req_valid,
    input  logic               ic_req_prior,
    input  logic [ADDR_W-1:0]  ic_req_addr,
    output logic               ic_req_accepted,
    output logic [TAG_W-1:0]   req_tag,
    input  logic               ic_squash,
    output logic [1:0]         proc2mem_command,
    output logic [ADDR_W-1:0]  proc2mem_addr,
    output logic [BLOCK_W-1:0] proc2mem_data,
    input  logic [TAG_W-1:0]   mem2proc_transaction_tag,
    input  logic [BLOCK_W-1:0] mem2proc_data,
    input  logic [TAG_W-1:0]   mem2proc_data_tag,
    output logic               dc_resp_valid,
    output logic               ic_resp_valid,
    output logic [TAG_W-1:0]   resp_tag,
    output logic [BLOCK_W-1:0] resp_data,
    output logic [TAG_W:0]     outstanding_cnt,
    output logic               err_bad_tag
);
    localparam int NT = 2 ** TAG_W;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {RUN, DRAIN} state_t;

    state_t         state;
    logic [NT-1:0]  ent_v, ent_own, ent_drop;
    logic [SW-1:0]  dc_starve, ic_starve;
    logic           last_ic;
    logic           dc_load, dc_store, room, dc_elig, ic_elig, dc_hungry, ic_hungry;
    logic           grant_dc, grant_ic, tag_ok, live, deliver, alloc, alloc_ic, free, ic_live, ic_live_after;
    logic [NT-1:0]  free_mask, alloc_mask;

    // Arbitration, issue and response routing are all combinational (0-cycle)
    always_comb begin
        dc_load          = dc_req_cmd == 2'd1;
        dc_store         = dc_req_cmd == 2'd2;
        room             = outstanding_cnt < (TAG_W+1)'(MAX_OUTSTANDING);
        dc_elig          = dc_req_valid && (dc_store || (dc_load && room));
        ic_elig          = ic_req_valid && state == RUN && !ic_squash && room;
        dc_hungry        = dc_starve == SW'(STARVE_LIMIT);
        ic_hungry        = ic_starve == SW'(STARVE_LIMIT);
        grant_dc         = dc_elig && (!ic_elig || dc_hungry ||
                           (!ic_hungry && (dc_req_prior || (!ic_req_prior && last_ic))));
        grant_ic         = ic_elig && !grant_dc;
        tag_ok           = mem2proc_transaction_tag != '0;
        dc_req_accepted  = grant_dc && (dc_store || tag_ok);
        ic_req_accepted  = grant_ic && tag_ok;
        alloc            = (grant_dc && dc_load && tag_ok) || ic_req_accepted;
        alloc_ic         = ic_req_accepted;
        req_tag          = alloc ? mem2proc_transaction_tag : '0;
        proc2mem_command = grant_dc ? dc_req_cmd : grant_ic ? 2'd1 : 2'd0;
        proc2mem_addr    = grant_dc ? dc_req_addr : grant_ic ? ic_req_addr : '0;
        proc2mem_data    = (grant_dc && dc_store) ? dc_req_data : '0;
        live             = mem2proc_data_tag != '0 && ent_v[mem2proc_data_tag];
        free             = live;
        deliver          = live && !ent_drop[mem2proc_data_tag];
        dc_resp_valid    = deliver && !ent_own[mem2proc_data_tag];
        ic_resp_valid    = deliver && ent_own[mem2proc_data_tag] && !ic_squash;
        resp_tag         = (dc_resp_valid || ic_resp_valid) ? mem2proc_data_tag : '0;
        resp_data        = (dc_resp_valid || ic_resp_valid) ? mem2proc_data : '0;
        free_mask        = free ? NT'(1) << mem2proc_data_tag : '0;
        alloc_mask       = alloc ? NT'(1) << mem2proc_transaction_tag : '0;
        ic_live          = |(ent_v & ent_own);
        ic_live_after    = |(ent_v & ent_own & ~free_mask);
    end

    // Tag table, counters, starvation guard and squash FSM; allocation overrides a same-tag free
    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= RUN;
            ent_v           <= '0;
            ent_own         <= '0;
            ent_drop        <= '0;
            dc_starve       <= '0;
            ic_starve       <= '0;
            last_ic         <= 1'b1;
            outstanding_cnt <= '0;
            err_bad_tag     <= 1'b0;
        end else begin
            ent_v           <= (ent_v & ~free_mask) | alloc_mask;
            ent_own         <= alloc_ic ? ent_own | alloc_mask : ent_own & ~alloc_mask;
            ent_drop        <= (ent_drop | (ic_squash ? ent_v & ent_own : '0)) & ~alloc_mask;
            outstanding_cnt <= outstanding_cnt + (TAG_W+1)'(alloc) - (TAG_W+1)'(free);
            dc_starve       <= (!dc_req_valid || dc_req_accepted) ? '0 : dc_hungry ? dc_starve : dc_starve + 1'b1;
            ic_starve       <= (!ic_req_valid || ic_req_accepted) ? '0 : ic_hungry ? ic_starve : ic_starve + 1'b1;
            last_ic         <= dc_req_accepted ? 1'b0 : ic_req_accepted ? 1'b1 : last_ic;
            err_bad_tag     <= err_bad_tag || (mem2proc_data_tag != '0 && !live);
            state           <= state == RUN ? ((ic_squash && ic_live) ? DRAIN : RUN)
                                            : (ic_live_after ? DRAIN : RUN);
        end
    end
endmodule

// File: tb/tb_mem_req_scheduler.sv
// tb_mem_req_scheduler: directed checks of arbitration, tag routing, squash drain and error flag
module tb_mem_req_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic        dc_req_valid, dc_req_prior, dc_req_accepted;
    logic [1:0]  dc_req_cmd;
    logic [31:0] dc_req_addr;
    logic [63:0] dc_req_data;
    logic        ic_req_valid, ic_req_prior, ic_req_accepted, ic_squash;
    logic [31:0] ic_req_addr;
    logic [3:0]  req_tag, mem2proc_transaction_tag, mem2proc_data_tag, resp_tag;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [63:0] proc2mem_data, mem2proc_data, resp_data;
    logic        dc_resp_valid, ic_resp_valid, err_bad_tag;
    logic [4:0]  outstanding_cnt;
    int          total = 0;
    int          bad = 0;

    localparam logic [31:0] A_DC = 32'h0000_1000;
    localparam logic [31:0] A_IC = 32'h0000_2000;
    localparam logic [63:0] D_ST = 64'hDEAD_BEEF_0123_4567;

    mem_req_scheduler dut (
        .clock(clock), .reset(reset),
        .dc_req_valid(dc_req_valid), .dc_req_cmd(dc_req_cmd), .dc_req_prior(dc_req_prior),
        .dc_req_addr(dc_req_addr), .dc_req_data(dc_req_data), .dc_req_accepted(dc_req_accepted),
        .ic_req_valid(ic_req_valid), .ic_req_prior(ic_req_prior), .ic_req_addr(ic_req_addr),
        .ic_req_accepted(ic_req_accepted), .req_tag(req_tag), .ic_squash(ic_squash),
        .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr), .proc2mem_data(proc2mem_data),
        .mem2proc_transaction_tag(mem2proc_transaction_tag), .mem2proc_data(mem2proc_data),
        .mem2proc_data_tag(mem2proc_data_tag), .dc_resp_valid(dc_resp_valid), .ic_resp_valid(ic_resp_valid),
        .resp_tag(resp_tag), .resp_data(resp_data), .outstanding_cnt(outstanding_cnt), .err_bad_tag(err_bad_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic idle();
        dc_req_valid = 0; dc_req_cmd = 0; dc_req_prior = 0; dc_req_addr = 0; dc_req_data = 0;
        ic_req_valid = 0; ic_req_prior = 0; ic_req_addr = 0; ic_squash = 0;
        mem2proc_transaction_tag = 0; mem2proc_data = 0; mem2proc_data_tag = 0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 0;
        idle();
        repeat (2) @(posedge clock);
        #1;
        chk("rst_cnt", outstanding_cnt, 0);
        chk("rst_err", err_bad_tag, 0);
        chk("rst_cmd", proc2mem_command, 0);
        chk("rst_acc", {dc_req_accepted, ic_req_accepted, dc_resp_valid, ic_resp_valid}, 0);
        reset = 1;
        // T1: round-robin with last grant = IC favours dcache, then icache
        dc_req_valid = 1; dc_req_cmd = 1; dc_req_addr = A_DC; dc_req_data = D_ST;
        ic_req_valid = 1; ic_req_addr = A_IC; mem2proc_transaction_tag = 3;
        #1;
        chk("t1_cmd", proc2mem_command, 1);
        chk("t1_addr", proc2mem_addr, A_DC);
        chk("t1_ldata", proc2mem_data, 0);
        chk("t1_dacc", dc_req_accepted, 1);
        chk("t1_iacc", ic_req_accepted, 0);
        chk("t1_tag", req_tag, 3);
        tick();
        chk("t1_cnt1", outstanding_cnt, 1);
        mem2proc_transaction_tag = 4;
        #1;
        chk("t1_rr_iacc", ic_req_accepted, 1);
        chk("t1_rr_dacc", dc_req_accepted, 0);
        chk("t1_rr_addr", proc2mem_addr, A_IC);
        chk("t1_rr_tag", req_tag, 4);
        tick();
        chk("t1_cnt2", outstanding_cnt, 2);
        // T2: responses routed to the issuing owner
        idle();
        mem2proc_data_tag = 3; mem2proc_data = 64'h33;
        #1;
        chk("t2_dresp", {dc_resp_valid, ic_resp_valid}, 2'b10);
        chk("t2_rtag3", resp_tag, 3);
        chk("t2_rdata3", resp_data, 64'h33);
        tick();
        chk("t2_cnt1", outstanding_cnt, 1);
        mem2proc_data_tag = 4; mem2proc_data = 64'h44;
        #1;
        chk("t2_iresp", {dc_resp_valid, ic_resp_valid}, 2'b01);
        chk("t2_rtag4", resp_tag, 4);
        tick();
        chk("t2_cnt0", outstanding_cnt, 0);
        // T3: high-priority dcache stores starve icache until the guard forces it through
        idle();
        dc_req_valid = 1; dc_req_cmd = 2; dc_req_prior = 1; dc_req_addr = A_DC; dc_req_data = D_ST;
        ic_req_valid = 1; ic_req_addr = A_IC; mem2proc_transaction_tag = 5;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("t3_lose_iacc", ic_req_accepted, 0);
            chk("t3_st_cmd", proc2mem_command, 2);
            tick();
        end
        #1;
        chk("t3_st_data", dc_req_accepted ? proc2mem_data : 64'h0, 0);
        chk("t3_win_iacc", ic_req_accepted, 1);
        chk("t3_win_dacc", dc_req_accepted, 0);
        chk("t3_win_tag", req_tag, 5);
        tick();
        #1;
        chk("t3_after_iacc", ic_req_accepted, 0);
        chk("t3_after_sdata", proc2mem_data, D_ST);
        chk("t3_st_reqtag", req_tag, 0);
        tick();
        chk("t3_cnt", outstanding_cnt, 1);
        idle();
        ic_req_valid = 1; ic_req_addr = A_IC; mem2proc_transaction_tag = 6;
        #1;
        chk("t4_pre_iacc", ic_req_accepted, 1);
        tick();
        chk("t4_pre_cnt", outstanding_cnt, 2);
        // T4: squash with live icache tags 5,6; dcache keeps working
        ic_squash = 1; dc_req_valid = 1; dc_req_cmd = 1; dc_req_addr = A_DC;
        mem2proc_transaction_tag = 7; mem2proc_data_tag = 5;
        #1;
        chk("t4_sq_iacc", ic_req_accepted, 0);
        chk("t4_sq_dacc", dc_req_accepted, 1);
        chk("t4_sq_iresp", ic_resp_valid, 0);
        chk("t4_sq_rtag", resp_tag, 0);
        tick();
        chk("t4_sq_cnt", outstanding_cnt, 2);
        idle();
        ic_req_valid = 1; ic_req_addr = A_IC; mem2proc_transaction_tag = 8; mem2proc_data_tag = 7;
        #1;
        chk("t4_drain_cmd", proc2mem_command, 0);
        chk("t4_drain_iacc", ic_req_accepted, 0);
        chk("t4_drain_dresp", dc_resp_valid, 1);
        tick();
        mem2proc_data_tag = 6;
        #1;
        chk("t4_drop6", ic_resp_valid, 0);
        chk("t4_drain2_iacc", ic_req_accepted, 0);
        tick();
        chk("t4_cnt0", outstanding_cnt, 0);
        mem2proc_data_tag = 0;
        #1;
        chk("t4_run_iacc", ic_req_accepted, 1);
        tick();
        idle();
        mem2proc_data_tag = 8;
        #1;
        chk("t4_run_iresp", ic_resp_valid, 1);
        tick();
        chk("t4_run_cnt", outstanding_cnt, 0);
        // T5: fill to the cap, loads blocked, stores pass, same-tag free+alloc
        idle();
        dc_req_valid = 1; dc_req_cmd = 1; dc_req_addr = A_DC;
        for (int i = 1; i <= 15; i++) begin
            mem2proc_transaction_tag = 4'(i);
            #1;
            chk("t5_fill_acc", dc_req_accepted, 1);
            tick();
        end
        chk("t5_full_cnt", outstanding_cnt, 15);
        ic_req_valid = 1; ic_req_addr = A_IC; mem2proc_transaction_tag = 3;
        #1;
        chk("t5_full_cmd", proc2mem_command, 0);
        chk("t5_full_acc", {dc_req_accepted, ic_req_accepted}, 0);
        chk("t5_full_tag", req_tag, 0);
        dc_req_cmd = 2; dc_req_data = D_ST;
        #1;
        chk("t5_store_cmd", proc2mem_command, 2);
        chk("t5_store_acc", dc_req_accepted, 1);
        tick();
        chk("t5_store_cnt", outstanding_cnt, 15);
        idle();
        mem2proc_data_tag = 5;
        #1;
        chk("t5_free5", dc_resp_valid, 1);
        tick();
        chk("t5_cnt14", outstanding_cnt, 14);
        ic_req_valid = 1; ic_req_addr = A_IC; mem2proc_transaction_tag = 6; mem2proc_data_tag = 6;
        #1;
        chk("t5_same_dresp", dc_resp_valid, 1);
        chk("t5_same_iacc", ic_req_accepted, 1);
        tick();
        chk("t5_same_cnt", outstanding_cnt, 14);
        idle();
        mem2proc_data_tag = 6;
        #1;
        chk("t5_newowner", {dc_resp_valid, ic_resp_valid}, 2'b01);
        tick();
        chk("t5_cnt13", outstanding_cnt, 13);
        // T6: reset forgets in-flight tags; stale response raises the sticky error
        idle();
        reset = 0;
        tick();
        reset = 1;
        chk("t6_rst_cnt", outstanding_cnt, 0);
        mem2proc_data_tag = 9;
        #1;
        chk("t6_noresp", {dc_resp_valid, ic_resp_valid}, 0);
        chk("t6_rtag", resp_tag, 0);
        tick();
        chk("t6_err", err_bad_tag, 1);
        mem2proc_data_tag = 0;
        tick();
        chk("t6_err_sticky", err_bad_tag, 1);
        reset = 0;
        tick();
        chk("t6_err_clr", err_bad_tag, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
